// File: rtl/fp32_mul_seq.sv
// fp32_mul_seq: sequential IEEE 754 single multiplier, 24-step shift-add mantissa product, RNE rounding, FTZ
module fp32_mul_seq #(
    parameter int E    = 8,
    parameter int F    = 23,
    parameter int BIAS = 127
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [E+F:0]     a_i,
    input  logic [E+F:0]     b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [E+F:0]     result_o,
    output logic             ovf_o,
    output logic             unf_o,
    output logic             nan_o
);
    localparam int M  = F + 1;
    localparam int W  = 1 + E + F;
    localparam int X  = E + 2;
    localparam int CW = $clog2(M);
    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*M-1:0]  acc_q, acc_d;
    logic [M-1:0]    ma_q, ma_d, mb_q, mb_d;
    logic [X-1:0]    exp_q, exp_d;
    logic            sign_q, sign_d;
    logic [W-1:0]    res_q, res_d;
    logic            ovf_q, ovf_d, unf_q, unf_d, nan_q, nan_d;

    logic [E-1:0] ea, eb;
    logic [F-1:0] fa, fb;
    logic         sign_in, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, spec, spec_nan;
    logic [W-1:0] spec_res;

    assign ea       = a_i[W-2 -: E];
    assign eb       = b_i[W-2 -: E];
    assign fa       = a_i[F-1:0];
    assign fb       = b_i[F-1:0];
    assign sign_in  = a_i[W-1] ^ b_i[W-1];
    assign a_zero   = ea == '0;
    assign b_zero   = eb == '0;
    assign a_inf    = &ea & ~|fa;
    assign b_inf    = &eb & ~|fb;
    assign a_nan    = &ea & |fa;
    assign b_nan    = &eb & |fb;
    assign spec     = a_zero | b_zero | &ea | &eb;
    assign spec_nan = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    assign spec_res = spec_nan ? QNAN :
                      (a_inf | b_inf) ? {sign_in, {E{1'b1}}, {F{1'b0}}} : {sign_in, {(W-1){1'b0}}};

    logic         hi, guard, sticky, inc, n_ovf, n_unf;
    logic [F-1:0] mant;
    logic [F:0]   mant_r;
    logic [X-1:0] exp_n;
    logic [W-1:0] norm_res;

    assign hi       = acc_q[2*M-1];
    assign mant     = hi ? acc_q[2*M-2 -: F] : acc_q[2*M-3 -: F];
    assign guard    = hi ? acc_q[M-1] : acc_q[M-2];
    assign sticky   = hi ? |acc_q[M-2:0] : |acc_q[M-3:0];
    assign inc      = guard & (sticky | mant[0]);
    assign mant_r   = {1'b0, mant} + (F+1)'(inc);
    assign exp_n    = exp_q + X'(hi) + X'(mant_r[F]);
    assign n_ovf    = ~exp_n[X-1] & (exp_n >= X'((1 << E) - 1));
    assign n_unf    = exp_n[X-1] | (exp_n == '0);
    assign norm_res = n_ovf ? {sign_q, {E{1'b1}}, {F{1'b0}}} :
                      n_unf ? {sign_q, {(W-1){1'b0}}} : {sign_q, exp_n[E-1:0], mant_r[F-1:0]};

    // Next-state and datapath update for accept, multiply iterations, normalise/round and output hold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        nan_d   = nan_q;
        case (state_q)
            IDLE: if (valid_i) begin
                sign_d = sign_in;
                if (spec) begin
                    state_d = HOLD;
                    res_d   = spec_res;
                    nan_d   = spec_nan;
                end else begin
                    state_d = MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ma_d    = {1'b1, fa};
                    mb_d    = {1'b1, fb};
                    exp_d   = X'(ea) + X'(eb) - X'(BIAS);
                end
            end
            MUL: begin
                acc_d   = mb_q[cnt_q] ? acc_q + ((2*M)'(ma_q) << cnt_q) : acc_q;
                cnt_d   = cnt_q == CW'(M - 1) ? '0 : cnt_q + CW'(1);
                state_d = cnt_q == CW'(M - 1) ? NORM : MUL;
            end
            NORM: begin
                res_d   = norm_res;
                ovf_d   = n_ovf;
                unf_d   = n_unf & ~n_ovf;
                state_d = HOLD;
            end
            HOLD: if (ready_i) begin
                state_d = IDLE;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                nan_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; asynchronous reset discards any operation in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            nan_q   <= nan_d;
        end
    end

    assign ready_o  = state_q == IDLE;
    assign valid_o  = state_q == HOLD;
    assign result_o = res_q;
    assign ovf_o    = ovf_q;
    assign unf_o    = unf_q;
    assign nan_o    = nan_q;
endmodule

// File: tb/tb_fp32_mul_seq.sv
// tb_fp32_mul_seq: scoreboard bench for the sequential fp32 multiplier
module tb_fp32_mul_seq;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;
    logic        ovf_o, unf_o, nan_o;

    int checks = 0;
    int errors = 0;
    logic [34:0] sb[$];

    fp32_mul_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .ovf_o(ovf_o), .unf_o(unf_o), .nan_o(nan_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_out(input string tag);
        logic [34:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_res"}, result_o, e[34:3]);
        chk({tag, "_flags"}, {29'd0, ovf_o, unf_o, nan_o}, {29'd0, e[2:0]});
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic o, input logic u, input logic n,
                          input int lat, input int hold);
        int k;
        logic [31:0] held;
        chk({tag, "_rdy"}, {31'd0, ready_o}, 32'd1);
        sb.push_back({r, o, u, n});
        a_i = a;
        b_i = b;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        k = 0;
        while (!valid_o && k < 100) begin
            tick();
            k++;
        end
        chk({tag, "_lat"}, k, lat);
        check_out(tag);
        held = result_o;
        for (int i = 0; i < hold; i++) begin
            valid_i = ~valid_i;
            a_i = $urandom;
            b_i = $urandom;
            tick();
            chk({tag, "_hold_res"}, result_o, held);
            chk({tag, "_hold_hs"}, {30'd0, ready_o, valid_o}, 32'd1);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk({tag, "_done"}, {28'd0, ready_o, valid_o, ovf_o | unf_o, nan_o}, 32'b1000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        tick();
        tick();
        chk("reset", {result_o[27:0], ready_o, valid_o, ovf_o | unf_o, nan_o}, 32'b1000);
        chk("reset_res", result_o, 32'h0);
        rst_i = 1'b0;
        tick();

        run_op("mul2x3",   32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 25, 0);
        run_op("mul15sq",  32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0, 25, 0);
        run_op("rnd_up",   32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0, 0, 25, 0);
        run_op("rnd_tie",  32'h3F800800, 32'h3F800800, 32'h3F801000, 0, 0, 0, 25, 0);
        run_op("near4",    32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 0, 0, 0, 25, 0);
        run_op("neg",      32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0, 0, 25, 0);
        run_op("ovf",      32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 0, 25, 0);
        run_op("unf",      32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 25, 0);
        run_op("minnorm",  32'h80800000, 32'h3F800000, 32'h80800000, 0, 0, 0, 25, 0);
        run_op("infzero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 1, 0, 0);
        run_op("zeroinf",  32'h80000000, 32'h7F800000, 32'h7FC00000, 0, 0, 1, 0, 0);
        run_op("nanin",    32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1, 0, 0);
        run_op("ninf",     32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 0, 0, 0);
        run_op("subn",     32'h00000001, 32'h40000000, 32'h00000000, 0, 0, 0, 0, 0);
        run_op("hold",     32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 25, 10);

        sb.push_back({32'h7FC00000, 3'b001});
        a_i = 32'h7F800000;
        b_i = 32'h00000000;
        valid_i = 1'b1;
        tick();
        chk("b2b_first_valid", {31'd0, valid_o}, 32'd1);
        check_out("b2b_first");
        sb.push_back({32'hFF800000, 3'b000});
        a_i = 32'h40000000;
        b_i = 32'hFF800000;
        ready_i = 1'b1;
        tick();
        chk("b2b_gap", {29'd0, ready_o, valid_o, nan_o}, 32'b100);
        tick();
        chk("b2b_second_valid", {30'd0, ready_o, valid_o}, 32'd1);
        check_out("b2b_second");
        valid_i = 1'b0;
        tick();
        ready_i = 1'b0;
        chk("b2b_idle", {30'd0, ready_o, valid_o}, 32'b10);

        a_i = 32'h40000000;
        b_i = 32'h40400000;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (10) tick();
        chk("mid_busy", {31'd0, ready_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        chk("mid_rst", {result_o[27:0], ready_o, valid_o, ovf_o | unf_o, nan_o}, 32'b1000);
        chk("mid_rst_res", result_o, 32'h0);
        tick();
        rst_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen |= valid_o;
        end
        chk("no_pulse", {31'd0, seen}, 32'd0);
        run_op("after_rst", 32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 25, 0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp32_mul_seq.md
Name: fp32_mul_seq

Overview:
- Sequential IEEE 754 single-precision multiplier; the inverse operation of the team's fp32 divider, and built as its companion in the ADC scaling datapath.
- Unsigned magnitude is produced by a 24-iteration shift-add mantissa multiplier; result sign is the XOR of the operand signs.
- Valid/ready handshake on input and output, so it chains directly with the divider and ADC sample pipeline.
- Subnormal inputs are flushed to zero; underflowing results are flushed to signed zero.

Parameters:
- E, 8, exponent width.
- F, 23, fraction width; word width is 1+E+F = 32.
- BIAS, 127, exponent bias.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  operands a_i/b_i are valid.
- ready_o  out  1  block is in IDLE and will accept operands.
- a_i  in  32  multiplicand, IEEE 754 single.
- b_i  in  32  multiplier, IEEE 754 single.
- valid_o  out  1  result_o and flags are valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  32  product, IEEE 754 single.
- ovf_o  out  1  exponent overflow occurred; result is signed infinity.
- unf_o  out  1  exponent underflow occurred; result is signed zero.
- nan_o  out  1  result is quiet NaN 0x7FC00000.

Behaviour:
- Reset: state IDLE, ready_o=1, valid_o=0, result_o=0, all flags 0, iteration counter 0, accumulator 0.
- States: IDLE, MUL, NORM, HOLD.
- IDLE: accept when valid_i && ready_o. The operands are registered on that edge.
  - If the operands are special, go directly to HOLD with the final result; valid_o rises 1 cycle after accept.
  - Otherwise go to MUL with cnt=0, acc=0, exp_sum = ea + eb - BIAS, computed in 10-bit signed.
- Special cases (an exponent field of 0 counts as zero, whatever its fraction):
  - Either operand NaN, or inf*zero -> 0x7FC00000, nan_o=1.
  - Inf * nonzero -> {sign, 0xFF, 0}; ovf_o stays 0.
  - Zero * finite -> {sign, 31'b0}.
- MUL: one iteration per cycle for 24 cycles, cnt 0..23.
  - If bit cnt of the 24-bit multiplier mantissa is 1, add (24-bit multiplicand mantissa << cnt) into the 48-bit accumulator.
  - At cnt==23, go to NORM.
- NORM, one cycle:
  - If P[47]=1: mant = P[46:24], guard = P[23], sticky = |P[22:0], exp = exp_sum + 1.
  - Else: mant = P[45:23], guard = P[22], sticky = |P[21:0], exp = exp_sum.
  - Rounding is round-to-nearest-even: increment when guard && (sticky || mant[0]).
  - Rounding carry-out sets mant = 0 and exp += 1.
  - If exp >= 255 -> signed infinity, ovf_o=1.
  - If exp <= 0 -> signed zero, unf_o=1.
  - Otherwise result = {sign, exp[7:0], mant}.
  - Go to HOLD.
- HOLD: valid_o=1; result_o and flags are stable.
  - Leave to IDLE on valid_o && ready_i; on that edge valid_o falls and ready_o rises.
  - With ready_i held high, the next operand can be accepted 1 cycle after the handshake cycle, never in the same cycle.
- Latency:
  - Normal operands: valid_o high 25 rising edges after the accept edge (24 MUL + 1 NORM).
  - Special operands: 1 edge.
- ready_o=0 in MUL, NORM and HOLD; valid_i is ignored there and the operands are not re-sampled.
- result_o is registered and changes only on entry to HOLD. Flags are cleared on leaving HOLD.
- rst_i asserted mid-operation (any state): immediate return to reset values; the partial product is discarded and no valid_o pulse follows.

Test Plan:
- Basic product: a=0x40000000 (2.0), b=0x40400000 (3.0) -> result 0x40C00000 after 25 cycles, all flags 0. Also 0x3FC00000*0x3FC00000 -> 0x40100000.
- Rounding, round up: a=b=0x3F800001 -> 0x3F800002.
- Rounding, tie to even: a=b=0x3F800800 -> 0x3F801000 (exact tie, rounds down).
- Overflow and underflow: 0x7F000000*0x7F000000 -> 0x7F800000 with ovf_o=1. 0x00800000*0x00800000 -> 0x00000000 with unf_o=1. 0x80800000*0x3F800000 -> 0x80800000.
- Specials, each with valid_o 1 cycle after accept:
  - 0x7F800000*0x00000000 -> 0x7FC00000, nan_o=1.
  - 0xFF800000*0x40000000 -> 0xFF800000, ovf_o=0.
  - 0x00000001 (subnormal) * 0x40000000 -> 0x00000000.
- Handshake and reset:
  - Hold ready_i=0 for 10 cycles in HOLD -> result stable, ready_o=0, toggling valid_i ignored. Raise ready_i -> ready_o rises next cycle.
  - Assert rst_i at MUL cnt=10 -> outputs at reset values; the next operation, 2.0*3.0, completes correctly.
